// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer for a
// single-port synchronous RAM (depth 2**ADDR_W, width DATA_W).
//
// Every access takes exactly three cycles: IDLE (sample/arbitrate) ->
// ISSUE (drive RAM pins, grant pulse) -> DONE (read data strobe) -> IDLE.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN   requester N command (held until gntN)
//   gntN                       one-cycle grant pulse (ISSUE cycle)
//   rvalidN                    one-cycle read-data-valid (DONE cycle)
//   rdata                      shared read data, zero unless an rvalid is high
//   mem_write/addr/data_in     RAM control pins (registered)
//   mem_data_out               RAM read data, valid the cycle after the address
//
// Optional build macro MEM_ARBITER_STATS_EN adds grant_cnt0/grant_cnt1:
// saturating 8-bit counts of each requester's ISSUE cycles.

// Per-requester output stage: registered grant / read-valid strobes and,
// when enabled, the saturating grant counter.
module mem_arbiter_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       gnt_d,
    input  logic       rvalid_d,
    output logic       gnt,
    output logic       rvalid
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [7:0] grant_cnt
`endif
);
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            gnt    <= gnt_d;
            rvalid <= rvalid_d;
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    // gnt is high exactly during this requester's ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset)
            grant_cnt <= 8'd0;
        else if (gnt && grant_cnt != 8'hFF)
            grant_cnt <= grant_cnt + 8'd1;
    end
`endif
endmodule

module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1
`endif
);
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    logic [NUM_REQ-1:0] req;
    cmd_t [NUM_REQ-1:0] req_cmd;

    assign req        = {req1, req0};
    assign req_cmd[0] = '{we: we0, addr: addr0, wdata: wdata0};
    assign req_cmd[1] = '{we: we1, addr: addr1, wdata: wdata1};

    // The address/data half of the command register lives directly in
    // mem_addr/mem_data_in; only the direction and winner need keeping.
    state_t             state_q, state_d;
    logic               is_read_q, is_read_d;
    logic               win_q, win_d;
    logic               last_winner_q, last_winner_d;
    logic               mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_data_in_d;
    logic [NUM_REQ-1:0] gnt_d, rvalid_d;
    logic [NUM_REQ-1:0] gnt_q, rvalid_q;
    logic               pick;
    cmd_t               sel_cmd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            win_q         <= 1'b0;
            last_winner_q <= 1'b1;  // requester 0 wins the first contention
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_data_in   <= '0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            win_q         <= win_d;
            last_winner_q <= last_winner_d;
            mem_write     <= mem_write_d;
            mem_addr      <= mem_addr_d;
            mem_data_in   <= mem_data_in_d;
        end
    end

    // Next-state and next-output logic. Outputs are registered, so the
    // values computed while in IDLE appear during ISSUE, and those
    // computed in ISSUE appear during DONE.
    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        win_d         = win_q;
        last_winner_d = last_winner_q;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr;
        mem_data_in_d = mem_data_in;
        gnt_d         = '0;
        rvalid_d      = '0;
        pick          = 1'b0;
        sel_cmd       = req_cmd[0];

        case (state_q)
            IDLE: begin
                if (|req) begin
                    // Contention goes to the requester that did not win last.
                    pick          = (&req) ? ~last_winner_q : req[1];
                    sel_cmd       = req_cmd[pick];
                    win_d         = pick;
                    last_winner_d = pick;
                    is_read_d     = ~sel_cmd.we;
                    gnt_d[pick]   = 1'b1;
                    mem_write_d   = sel_cmd.we;
                    mem_addr_d    = sel_cmd.addr;
                    mem_data_in_d = sel_cmd.wdata;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                rvalid_d[win_q] = is_read_q;
                state_d         = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][7:0] grant_cnt;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        mem_arbiter_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .gnt_d    (gnt_d[i]),
            .rvalid_d (rvalid_d[i]),
            .gnt      (gnt_q[i]),
            .rvalid   (rvalid_q[i])
`ifdef MEM_ARBITER_STATS_EN
            ,
            .grant_cnt(grant_cnt[i])
`endif
        );
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];

`ifdef MEM_ARBITER_STATS_EN
    assign grant_cnt0 = grant_cnt[0];
    assign grant_cnt1 = grant_cnt[1];
`endif

    // RAM output is passed straight through, gated so rdata is zero
    // outside a read-valid cycle.
    assign rdata = (|rvalid_q) ? mem_data_out : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [4:0] addr0, addr1;
    logic [2:0] wdata0, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [2:0] rdata;
    logic       mem_write;
    logic [4:0] mem_addr;
    logic [2:0] mem_data_in;
    logic [2:0] mem_data_out;
`ifdef MEM_ARBITER_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(5), .DATA_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .gnt0        (gnt0),
        .rvalid0     (rvalid0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .gnt1        (gnt1),
        .rvalid1     (rvalid1),
        .rdata       (rdata),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // 32 x 3 synchronous RAM, read-first.
    logic [2:0] ram [32];
    initial for (int i = 0; i < 32; i++) ram[i] = 3'd0;
    initial mem_data_out = 3'd0;
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_data_in;
        mem_data_out <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         who;
        bit         we;
        logic [4:0] addr;
        logic [2:0] wdata;
        logic [2:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    // One single-requester access, checked through ISSUE, DONE and the idle cycle after.
    task automatic do_txn(input vec_t v);
        if (v.who == 1'b0) begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end
        tick();  // ISSUE
        chk("issue_gnt0",    gnt0, v.who == 1'b0);
        chk("issue_gnt1",    gnt1, v.who == 1'b1);
        chk("issue_mem_write", mem_write, v.we);
        chk("issue_mem_addr",  mem_addr, v.addr);
        chk("issue_mem_data_in", mem_data_in, v.wdata);
        chk("issue_rvalid",  {rvalid1, rvalid0}, 0);
        req0 = 1'b0; req1 = 1'b0;
        tick();  // DONE
        chk("done_rvalid0",  rvalid0, !v.we && v.who == 1'b0);
        chk("done_rvalid1",  rvalid1, !v.we && v.who == 1'b1);
        chk("done_rdata",    rdata, v.we ? 3'd0 : v.exp_rdata);
        chk("done_mem_write", mem_write, 0);
        chk("done_mem_addr", mem_addr, v.addr);
        chk("done_gnt",      {gnt1, gnt0}, 0);
        tick();  // IDLE
        chk("idle_pulses",   {gnt1, gnt0, rvalid1, rvalid0}, 0);
        chk("idle_rdata",    rdata, 0);
    endtask

    initial begin
        vecs[0] = '{who: 0, we: 1, addr: 5'd3,  wdata: 3'd6, exp_rdata: 3'd0};
        vecs[1] = '{who: 0, we: 0, addr: 5'd3,  wdata: 3'd0, exp_rdata: 3'd6};
        vecs[2] = '{who: 1, we: 1, addr: 5'd31, wdata: 3'd5, exp_rdata: 3'd0};
        vecs[3] = '{who: 1, we: 0, addr: 5'd31, wdata: 3'd2, exp_rdata: 3'd5};
        vecs[4] = '{who: 0, we: 1, addr: 5'd0,  wdata: 3'd1, exp_rdata: 3'd0};
        vecs[5] = '{who: 1, we: 0, addr: 5'd0,  wdata: 3'd0, exp_rdata: 3'd1};
        vecs[6] = '{who: 0, we: 1, addr: 5'd4,  wdata: 3'd2, exp_rdata: 3'd0};
        vecs[7] = '{who: 1, we: 1, addr: 5'd5,  wdata: 3'd7, exp_rdata: 3'd0};
        vecs[8] = '{who: 0, we: 0, addr: 5'd5,  wdata: 3'd3, exp_rdata: 3'd7};
        vecs[9] = '{who: 1, we: 0, addr: 5'd4,  wdata: 3'd0, exp_rdata: 3'd2};

        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) tick();
        chk("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_write}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_data_in", mem_data_in, 0);
        chk("reset_rdata", rdata, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_req", {gnt0, gnt1, rvalid0, rvalid1, mem_write}, 0);
        end

        foreach (vecs[i]) do_txn(vecs[i]);

        // Sustained contention: reads of addr 4 (=2) and addr 5 (=7); 0 wins first.
        req0 = 1; we0 = 0; addr0 = 5'd4; wdata0 = 0;
        req1 = 1; we1 = 0; addr1 = 5'd5; wdata1 = 0;
        for (int k = 0; k < 12; k++) begin
            int ph, w;
            tick();
            ph = k % 3;
            w  = (k / 3) % 2;
            chk("rr_gnt0",    gnt0,    ph == 0 && w == 0);
            chk("rr_gnt1",    gnt1,    ph == 0 && w == 1);
            chk("rr_rvalid0", rvalid0, ph == 1 && w == 0);
            chk("rr_rvalid1", rvalid1, ph == 1 && w == 1);
            chk("rr_rdata",   rdata,   ph != 1 ? 3'd0 : (w == 0 ? 3'd2 : 3'd7));
            chk("rr_exclusive", (gnt0 & gnt1) | (rvalid0 & rvalid1), 0);
        end
        req0 = 0; req1 = 0;
        tick();
        chk("rr_drained", {gnt0, gnt1, rvalid0, rvalid1}, 0);

        // Reset during ISSUE of a requester-0 read.
        req0 = 1; we0 = 0; addr0 = 5'd4;
        tick();
        chk("rst_pre_gnt0", gnt0, 1);
        req0 = 0;
        reset = 1'b1;
        tick();
        chk("rst_mid_pulses", {gnt0, gnt1, rvalid0, rvalid1, mem_write}, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        chk("rst_mid_rdata", rdata, 0);
        reset = 1'b0;
        tick();
        chk("rst_no_late_rvalid", {gnt0, gnt1, rvalid0, rvalid1}, 0);
        // After reset, requester 0 is preferred even though it won last.
        req0 = 1; we0 = 0; addr0 = 5'd4;
        req1 = 1; we1 = 0; addr1 = 5'd5;
        tick();
        chk("post_rst_gnt0", gnt0, 1);
        chk("post_rst_gnt1", gnt1, 0);
        req0 = 0;
        tick();
        chk("post_rst_rvalid0", rvalid0, 1);
        chk("post_rst_rdata0", rdata, 2);
        tick();
        chk("post_rst_idle", {gnt1, rvalid1}, 0);
        tick();
        chk("post_rst_gnt1_later", gnt1, 1);
        req1 = 0;
        tick();
        chk("post_rst_rvalid1", rvalid1, 1);
        chk("post_rst_rdata1", rdata, 7);
        tick();

`ifdef MEM_ARBITER_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cnt0_after_reset", grant_cnt0, 0);
        chk("cnt1_after_reset", grant_cnt1, 0);
        req0 = 1; we0 = 1; addr0 = 5'd7; wdata0 = 3'd3;
        repeat (30) tick();
        chk("cnt0_partial", grant_cnt0, 10);
        repeat (870) tick();
        req0 = 0;
        repeat (3) tick();
        chk("cnt0_saturated", grant_cnt0, 255);
        chk("cnt1_untouched", grant_cnt1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cnt0_cleared", grant_cnt0, 0);
        chk("cnt1_cleared", grant_cnt1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM (`memory`, 32 x 3-bit).
- Each requester issues read or write commands over a req/gnt handshake. The arbiter serialises them onto the RAM's write/addr/data_in pins and returns read data with a per-requester valid strobe.
- Sits between the client logic and the `memory` instance. It is the only driver of the RAM control pins.

Parameters:
- ADDR_W, 5, RAM address width (depth = 2**ADDR_W)
- DATA_W, 3, RAM data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 access request, held until gnt0
- we0  input  1  requester 0: 1 = write, 0 = read; valid with req0
- addr0  input  ADDR_W  requester 0 address
- wdata0  input  DATA_W  requester 0 write data
- gnt0  output  1  one-cycle grant pulse to requester 0
- rvalid0  output  1  one-cycle read-data-valid to requester 0
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as above, for requester 1
- rdata  output  DATA_W  read data, shared; qualified by rvalid0/rvalid1
- mem_write  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address
- mem_data_in  output  DATA_W  RAM write data
- mem_data_out  input  DATA_W  RAM read data; valid the cycle after mem_addr is presented with mem_write=0

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values (all registered outputs): gnt0/1=0, rvalid0/1=0, mem_write=0, mem_addr=0, mem_data_in=0, state=IDLE, last_winner=1 (so requester 0 wins the first contention).
- FSM states: IDLE, ISSUE, DONE. Every access takes exactly 3 cycles: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - Sample req0/req1. If neither is set, stay in IDLE.
  - If exactly one is set, that requester wins.
  - If both are set, the requester != last_winner wins.
  - Latch the winner's we/addr/wdata into the command register, update last_winner, go to ISSUE.
- ISSUE:
  - mem_addr = latched addr; mem_data_in = latched wdata; mem_write = latched we.
  - gnt of the winner = 1 for this cycle only.
  - Always go to DONE.
- DONE:
  - mem_write = 0; mem_addr holds its value.
  - If the access was a read: rvalid of the winner = 1 and rdata = mem_data_out (combinational pass-through of the RAM output).
  - If the access was a write: no rvalid.
  - Always go to IDLE.
- Requester rule: req must be held from assertion until gnt is seen, and must be low by the DONE cycle. Any req still high in the following IDLE is treated as a new request.
- Requests are sampled only in IDLE. Requests raised during ISSUE or DONE wait; nothing is lost.
- rdata = 0 whenever neither rvalid is high.
- gnt and rvalid are never asserted to both requesters in the same cycle.
- Sustained contention strictly alternates 0,1,0,1...
- Addresses wrap naturally within ADDR_W. No range check.
- Reset mid-access (ISSUE or DONE): next cycle is IDLE with all outputs at reset values. A pending write may or may not have completed in the RAM. No gnt or rvalid is emitted after reset.
- Arbitrating while RAM reset is asserted: reset is shared, so both blocks restart together.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN
- With the macro defined:
  - Two extra output ports, grant_cnt0 and grant_cnt1 (8 bits each).
  - Each counts that requester's ISSUE cycles and saturates at 255.
  - Both are cleared by reset.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> all outputs 0. state IDLE; mem_write=0 for 5 cycles with no req.
- Req0 write addr=5'b00011 wdata=3'b110 -> gnt0 pulses 1 cycle after req sampled; mem_write=1, mem_addr=3, mem_data_in=6 in that cycle. Then req0 read addr=3 -> rvalid0=1, rdata=3'b110 exactly 2 cycles after the IDLE sample.
- req0 and req1 both held continuously (reads, addr 4 and 5) -> grants 0,1,0,1 every 3 cycles; rvalid0 and rvalid1 never coincide.
- req1 alone, write addr=5'b11111 wdata=3'b101, then read -> rvalid1=1, rdata=3'b101; gnt0 and rvalid0 stay 0.
- Assert reset during ISSUE of a read -> next cycle gnt=0, rvalid=0, mem_write=0, state IDLE. The following request is served normally, with requester 0 preferred on contention.
- With MEM_ARBITER_STATS_EN: 300 back-to-back requester-0 accesses -> grant_cnt0=255, grant_cnt1=0. After reset both are 0.
